// File: rtl/call_stack_unit.sv
// call_stack_unit: hardware return-address stack for subroutine call/return,
// with registered pop output and sticky overflow/underflow flags.
module call_stack_unit #(
   parameter int AW    = 13,
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_addr,
   input  logic          err_clr,
   output logic [AW-1:0] ret_addr,
   output logic          ret_valid,
   output logic [AW-1:0] top,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic          underflow
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [AW-1:0] mem [DEPTH];
   logic [CW-1:0] countDec, countNext;
   logic [IW-1:0] topIdx, pushIdx, wrIdx;
   logic          popOk, wrEn, ovfSet, unfSet;
   assign countDec  = count - CW'(1);
   assign topIdx    = IW'(countDec % CW'(DEPTH));
   assign pushIdx   = IW'(count % CW'(DEPTH));
   assign empty     = count == '0;
   assign full      = count == CW'(DEPTH);
   assign top       = empty ? '0 : mem[topIdx];
   assign popOk     = pop && !empty;
   // A pop alongside a push frees the top slot, so a swap is legal even when full.
   assign wrEn      = push && (!full || popOk);
   assign wrIdx     = popOk ? topIdx : pushIdx;
   assign ovfSet    = push && full && !popOk;
   assign unfSet    = pop && empty;
   always_comb begin
      countNext = count;
      if (wrEn && !popOk)
         countNext = count + CW'(1);
      else if (popOk && !wrEn)
         countNext = countDec;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         count     <= '0;
         ret_addr  <= '0;
         ret_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= countNext;
         ret_valid <= popOk;
         if (popOk)
            ret_addr <= top;
         overflow  <= ovfSet | (overflow & ~err_clr);
         underflow <= unfSet | (underflow & ~err_clr);
      end
   end
   always_ff @(posedge clk) begin
      if (rst && wrEn)
         mem[wrIdx] <= push_addr;
   end
endmodule

// File: tb/tb_call_stack_unit.sv
// tb_call_stack_unit: directed stimulus with a scoreboard queue of expected
// popped addresses, checked by an independent monitor on every ret_valid.
module tb_call_stack_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [12:0] push_addr = '0;
   logic        err_clr = 1'b0;
   logic [12:0] ret_addr;
   logic        ret_valid;
   logic [12:0] top;
   logic [3:0]  count;
   logic        empty, full, overflow, underflow;

   int vectors = 0;
   int miscompares = 0;
   logic [12:0] expQ [$];

   call_stack_unit #(.AW(13), .DEPTH(8), .CW(4)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
      .err_clr(err_clr), .ret_addr(ret_addr), .ret_valid(ret_valid), .top(top),
      .count(count), .empty(empty), .full(full), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected pops are queued before the edge; the monitor requires them on that very edge.
   task automatic cyc(input logic r, input logic ps, input logic pp, input logic [12:0] a,
                      input logic clr, input logic expPop, input logic [12:0] expAddr);
      @(negedge clk);
      rst = r;
      push = ps;
      pop = pp;
      push_addr = a;
      err_clr = clr;
      if (expPop)
         expQ.push_back(expAddr);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      if (ret_valid) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ret_valid_unexpected: got ret_valid=1 ret_addr=0x%0h expected ret_valid=0", ret_addr);
         end else begin
            chk("ret_addr_pop", 32'(ret_addr), 32'(expQ.pop_front()));
         end
      end else if (expQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL ret_valid_missing: got ret_valid=0 expected ret_valid=1 ret_addr=0x%0h", expQ.pop_front());
      end
   end

   initial begin
      // Reset held with push asserted
      cyc(0, 1, 0, 13'h0005, 0, 0, 0);
      cyc(0, 1, 0, 13'h0005, 0, 0, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_ret_valid", 32'(ret_valid), 0);
      chk("rst_ret_addr", 32'(ret_addr), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_underflow", 32'(underflow), 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      // LIFO order
      cyc(1, 1, 0, 13'h0010, 0, 0, 0);
      cyc(1, 1, 0, 13'h0020, 0, 0, 0);
      cyc(1, 1, 0, 13'h0030, 0, 0, 0);
      chk("lifo_count", 32'(count), 3);
      chk("lifo_top", 32'(top), 32'h30);
      cyc(1, 0, 1, 0, 0, 1, 13'h0030);
      cyc(1, 0, 1, 0, 0, 1, 13'h0020);
      cyc(1, 0, 1, 0, 0, 1, 13'h0010);
      chk("lifo_empty", 32'(empty), 1);
      chk("lifo_top_empty", 32'(top), 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("lifo_pulse_end", 32'(ret_valid), 0);
      chk("lifo_addr_held", 32'(ret_addr), 32'h10);
      // Fill to DEPTH then one more
      for (int i = 1; i <= 9; i++) begin
         cyc(1, 1, 0, 13'(32'h100 + i), 0, 0, 0);
         if (i == 8) begin
            chk("full_flag", 32'(full), 1);
            chk("full_count", 32'(count), 8);
            chk("full_no_ovf_yet", 32'(overflow), 0);
         end
      end
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 8);
      chk("ovf_top", 32'(top), 32'h108);
      for (int i = 8; i >= 1; i--)
         cyc(1, 0, 1, 0, 0, 1, 13'(32'h100 + i));
      chk("drain_empty", 32'(empty), 1);
      chk("drain_full", 32'(full), 0);
      // Underflow and sticky clear
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("unf_flag", 32'(underflow), 1);
      chk("unf_ret_valid", 32'(ret_valid), 0);
      chk("unf_ret_addr", 32'(ret_addr), 32'h101);
      chk("unf_count", 32'(count), 0);
      cyc(1, 0, 0, 0, 1, 0, 0);
      chk("clr_unf", 32'(underflow), 0);
      chk("clr_ovf", 32'(overflow), 0);
      cyc(1, 0, 1, 0, 1, 0, 0);
      chk("clr_set_wins", 32'(underflow), 1);
      cyc(1, 0, 0, 0, 1, 0, 0);
      chk("clr_again", 32'(underflow), 0);
      // Swap on a two-entry stack
      cyc(1, 1, 0, 13'h0100, 0, 0, 0);
      cyc(1, 1, 0, 13'h0200, 0, 0, 0);
      cyc(1, 1, 1, 13'h1FFF, 0, 1, 13'h0200);
      chk("swap_count", 32'(count), 2);
      chk("swap_top", 32'(top), 32'h1FFF);
      chk("swap_no_unf", 32'(underflow), 0);
      cyc(1, 0, 1, 0, 0, 1, 13'h1FFF);
      cyc(1, 0, 1, 0, 0, 1, 13'h0100);
      // Swap while full
      for (int i = 1; i <= 8; i++)
         cyc(1, 1, 0, 13'(32'h300 + i), 0, 0, 0);
      cyc(1, 1, 1, 13'h0ABC, 0, 1, 13'h0308);
      chk("swapf_ovf", 32'(overflow), 0);
      chk("swapf_count", 32'(count), 8);
      chk("swapf_full", 32'(full), 1);
      chk("swapf_top", 32'(top), 32'hABC);
      cyc(1, 0, 1, 0, 0, 1, 13'h0ABC);
      for (int i = 7; i >= 1; i--)
         cyc(1, 0, 1, 0, 0, 1, 13'(32'h300 + i));
      // Push and pop together on empty
      cyc(1, 1, 1, 13'h0777, 0, 0, 0);
      chk("pe_count", 32'(count), 1);
      chk("pe_top", 32'(top), 32'h777);
      chk("pe_unf", 32'(underflow), 1);
      chk("pe_ret_valid", 32'(ret_valid), 0);
      cyc(1, 0, 1, 0, 1, 1, 13'h0777);
      chk("pe_clr", 32'(underflow), 0);
      // Reset in the middle of a pop
      cyc(1, 1, 0, 13'h0011, 0, 0, 0);
      cyc(1, 1, 0, 13'h0022, 0, 0, 0);
      cyc(1, 1, 0, 13'h0033, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("mrst_count", 32'(count), 0);
      chk("mrst_ret_valid", 32'(ret_valid), 0);
      chk("mrst_ret_addr", 32'(ret_addr), 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("mrst_unf", 32'(underflow), 1);
      chk("mrst_pop_valid", 32'(ret_valid), 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("scoreboard_drained", 32'(expQ.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
